// File: rtl/mem_access_unit.sv
// Load/store initiator for a word-wide data memory. It supports byte, half and word accesses
// with big-endian lanes and uses read-modify-write for sub-word stores.
module mem_access_unit #(
    parameter int             W         = 32,
    parameter logic [W-1:0]   PARK_ADDR = 32'hFFFF_FFFC
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_we,
    input  logic [1:0]   req_size,
    input  logic         req_signed,
    input  logic [W-1:0] req_addr,
    input  logic [W-1:0] req_wdata,
    output logic         resp_valid,
    output logic [W-1:0] resp_rdata,
    output logic         resp_err,
    output logic [W-1:0] dm_addr,
    output logic [W-1:0] dm_wdata,
    output logic         dm_we,
    output logic         dm_re,
    input  logic [W-1:0] dm_rdata
);

    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, STORE, RESP} state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t         state, state_nxt;
    logic [W-1:0]   dm_addr_nxt, dm_wdata_nxt, resp_rdata_nxt;
    logic           dm_we_nxt, dm_re_nxt, resp_valid_nxt, resp_err_nxt;
    logic           latch;
    logic           req_bad;

    logic [1:0]     addr_lo_p0;
    logic [1:0]     size_p0;
    logic           signed_p0;
    logic [W-1:0]   wdata_p0;

    // Extract the addressed lane from a read word and extend it to W bits.
    function automatic logic [W-1:0] load_extract(input logic [W-1:0] rd, input logic [1:0] k,
                                                  input logic [1:0] sz, input logic sgn);
        logic [W-1:0]        shifted;
        logic signed [7:0]   byte_s;
        logic signed [15:0]  half_s;
        logic [W-1:0]        res;
        shifted = rd >> {~k, 3'b000};
        byte_s  = shifted[7:0];
        half_s  = k[1] ? rd[15:0] : rd[31:16];
        case (sz)
            SZ_BYTE: res = {{(W-8){byte_s[7] & sgn}}, byte_s};
            SZ_HALF: res = {{(W-16){half_s[15] & sgn}}, half_s};
            default: res = rd;
        endcase
        return res;
    endfunction

    // Replace only the addressed byte/half lane of the read word with the store data.
    function automatic logic [W-1:0] rmw_merge(input logic [W-1:0] rd, input logic [W-1:0] wd,
                                               input logic [1:0] k, input logic [1:0] sz);
        logic [4:0]   sh;
        logic [W-1:0] mask;
        logic [W-1:0] lane;
        if (sz == SZ_BYTE) begin
            sh   = {~k, 3'b000};
            mask = {{(W-8){1'b0}}, 8'hFF} << sh;
            lane = {{(W-8){1'b0}}, wd[7:0]} << sh;
        end else begin
            sh   = {~k[1], 4'b0000};
            mask = {{(W-16){1'b0}}, 16'hFFFF} << sh;
            lane = {{(W-16){1'b0}}, wd[15:0]} << sh;
        end
        return (rd & ~mask) | lane;
    endfunction

    assign req_ready = (state == IDLE);
    assign req_bad   = (req_size == 2'b11) ||
                       (req_size == SZ_HALF && req_addr[0]) ||
                       (req_size == SZ_WORD && req_addr[1:0] != 2'b00);

    // Next-state and next-output decode; all dm_*/resp_* outputs are registered below.
    always_comb begin
        state_nxt      = state;
        dm_addr_nxt    = PARK_ADDR;
        dm_wdata_nxt   = dm_wdata;
        dm_we_nxt      = 1'b0;
        dm_re_nxt      = 1'b0;
        resp_valid_nxt = 1'b0;
        resp_rdata_nxt = resp_rdata;
        resp_err_nxt   = 1'b0;
        latch          = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    latch = 1'b1;
                    if (req_bad) begin
                        state_nxt      = RESP;
                        resp_valid_nxt = 1'b1;
                        resp_err_nxt   = 1'b1;
                        resp_rdata_nxt = '0;
                    end else if (!req_we) begin
                        state_nxt   = LOAD;
                        dm_addr_nxt = {req_addr[W-1:2], 2'b00};
                        dm_re_nxt   = 1'b1;
                    end else if (req_size == SZ_WORD) begin
                        state_nxt    = STORE;
                        dm_addr_nxt  = {req_addr[W-1:2], 2'b00};
                        dm_we_nxt    = 1'b1;
                        dm_wdata_nxt = req_wdata;
                    end else begin
                        state_nxt   = RMW_RD;
                        dm_addr_nxt = {req_addr[W-1:2], 2'b00};
                        dm_re_nxt   = 1'b1;
                    end
                end
            end
            LOAD: begin
                state_nxt      = RESP;
                resp_valid_nxt = 1'b1;
                resp_rdata_nxt = load_extract(dm_rdata, addr_lo_p0, size_p0, signed_p0);
            end
            RMW_RD: begin
                state_nxt    = STORE;
                dm_addr_nxt  = dm_addr;
                dm_we_nxt    = 1'b1;
                dm_wdata_nxt = rmw_merge(dm_rdata, wdata_p0, addr_lo_p0, size_p0);
            end
            STORE: begin
                state_nxt      = RESP;
                resp_valid_nxt = 1'b1;
                resp_rdata_nxt = '0;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            dm_addr    <= PARK_ADDR;
            dm_wdata   <= '0;
            dm_we      <= 1'b0;
            dm_re      <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            state      <= state_nxt;
            dm_addr    <= dm_addr_nxt;
            dm_wdata   <= dm_wdata_nxt;
            dm_we      <= dm_we_nxt;
            dm_re      <= dm_re_nxt;
            resp_valid <= resp_valid_nxt;
            resp_rdata <= resp_rdata_nxt;
            resp_err   <= resp_err_nxt;
        end
    end

    // Request fields kept for the later access/merge cycles.
    always_ff @(posedge clk) begin
        if (latch) begin
            addr_lo_p0 <= req_addr[1:0];
            size_p0    <= req_size;
            signed_p0  <= req_signed;
            wdata_p0   <= req_wdata;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: a vector table and a response scoreboard, together
// with hand-written reset-abort and back-to-back sequences.
module tb_mem_access_unit;

    localparam logic [31:0] PARK = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_err, dm_we, dm_re;
    logic [31:0] resp_rdata, dm_addr, dm_wdata, dm_rdata;

    mem_access_unit dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we), .dm_re(dm_re), .dm_rdata(dm_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: combinational read, write at the rising edge.
    logic [31:0] mem [0:15];
    logic        load_mem = 1'b1;
    assign dm_rdata = mem[dm_addr[5:2]];
    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h5555_5555;
            mem[0] <= 32'h0102_0304;
            mem[2] <= 32'h11F2_3344;
            mem[3] <= 32'h8000_FF7F;
        end else if (dm_we) begin
            mem[dm_addr[5:2]] <= dm_wdata;
        end
    end

    int chk_cnt = 0, pass_cnt = 0, cyc = 0, re_cnt = 0, we_cnt = 0;
    logic [31:0] last_wdata = '0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
        int          lat;
    } exp_t;
    exp_t sb[$];

    // Response monitor: every resp_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst) begin
            if (dm_re) re_cnt++;
            if (dm_we) begin
                we_cnt++;
                last_wdata = dm_wdata;
            end
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_resp", 32'(resp_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("resp_rdata", resp_rdata, e.rdata);
                    chk("resp_err", 32'(resp_err), 32'(e.err));
                    chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
                end
            end
        end
    end

    typedef struct {
        string       nm;
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          lat;
        int          exp_re;
        int          exp_we;
        logic [31:0] exp_wdata;
    } vec_t;
    vec_t vecs[$];

    task automatic drive(input vec_t v);
        req_valid = 1'b1; req_we = v.we; req_size = v.size; req_signed = v.sgn;
        req_addr = v.addr; req_wdata = v.wdata;
    endtask

    task automatic issue(input vec_t v);
        int n;
        @(negedge clk);
        drive(v);
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk_cnt++;
            $display("FAIL accept_timeout %s: req_ready stuck at 0", v.nm);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        sb.push_back('{v.exp_rdata, v.exp_err, cyc, v.lat});
        req_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            chk_cnt++;
            $display("FAIL resp_timeout %s: %0d responses missing", nm, sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int re0, we0, acc1, n;
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int re0, we0, acc1, acc2, n;
        vec_t v;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dm_addr", dm_addr, PARK);
        chk("rst_dm_we", 32'(dm_we), 32'd0);
        chk("rst_dm_re", 32'(dm_re), 32'd0);
        chk("rst_dm_wdata", dm_wdata, 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        load_mem = 1'b0;

        //            name     we  sz    sg  addr   wdata          exp_rdata      err lat re we exp_wdata
        vecs.push_back('{"lw8",  0, 2'b10, 0, 32'h8, 32'h0,        32'h11F23344, 0, 2, 1, 0, 32'h0});
        vecs.push_back('{"lb9",  0, 2'b00, 1, 32'h9, 32'h0,        32'hFFFFFFF2, 0, 2, 1, 0, 32'h0});
        vecs.push_back('{"lbu9", 0, 2'b00, 0, 32'h9, 32'h0,        32'h000000F2, 0, 2, 1, 0, 32'h0});
        vecs.push_back('{"lhA",  0, 2'b01, 1, 32'hA, 32'h0,        32'h00003344, 0, 2, 1, 0, 32'h0});
        vecs.push_back('{"lh8",  0, 2'b01, 1, 32'h8, 32'h0,        32'h000011F2, 0, 2, 1, 0, 32'h0});
        vecs.push_back('{"lhC",  0, 2'b01, 1, 32'hC, 32'h0,        32'hFFFF8000, 0, 2, 1, 0, 32'h0});
        vecs.push_back('{"lhuE", 0, 2'b01, 0, 32'hE, 32'h0,        32'h0000FF7F, 0, 2, 1, 0, 32'h0});
        vecs.push_back('{"lbF",  0, 2'b00, 1, 32'hF, 32'h0,        32'h0000007F, 0, 2, 1, 0, 32'h0});
        vecs.push_back('{"lbE",  0, 2'b00, 1, 32'hE, 32'h0,        32'hFFFFFFFF, 0, 2, 1, 0, 32'h0});
        vecs.push_back('{"sbB",  1, 2'b00, 0, 32'hB, 32'hFFFFFFAB, 32'h0,        0, 3, 1, 1, 32'h11F233AB});
        vecs.push_back('{"lw8b", 0, 2'b10, 0, 32'h8, 32'h0,        32'h11F233AB, 0, 2, 1, 0, 32'h0});
        vecs.push_back('{"lw6",  0, 2'b10, 0, 32'h6, 32'h0,        32'h0,        1, 1, 0, 0, 32'h0});
        vecs.push_back('{"sh5",  1, 2'b01, 0, 32'h5, 32'h1234,     32'h0,        1, 1, 0, 0, 32'h0});
        vecs.push_back('{"sz3",  0, 2'b11, 0, 32'h8, 32'h0,        32'h0,        1, 1, 0, 0, 32'h0});
        vecs.push_back('{"lh9",  0, 2'b01, 0, 32'h9, 32'h0,        32'h0,        1, 1, 0, 0, 32'h0});
        vecs.push_back('{"lw4",  0, 2'b10, 0, 32'h4, 32'h0,        32'h55555555, 0, 2, 1, 0, 32'h0});
        vecs.push_back('{"sh8",  1, 2'b01, 0, 32'h8, 32'h0000BEEF, 32'h0,        0, 3, 1, 1, 32'hBEEF33AB});
        vecs.push_back('{"lw8c", 0, 2'b10, 0, 32'h8, 32'h0,        32'hBEEF33AB, 0, 2, 1, 0, 32'h0});
        vecs.push_back('{"sw4",  1, 2'b10, 0, 32'h4, 32'hCAFEF00D, 32'h0,        0, 2, 0, 1, 32'hCAFEF00D});
        vecs.push_back('{"lw4b", 0, 2'b10, 0, 32'h4, 32'h0,        32'hCAFEF00D, 0, 2, 1, 0, 32'h0});

        foreach (vecs[i]) begin
            re0 = re_cnt;
            we0 = we_cnt;
            issue(vecs[i]);
            drain(vecs[i].nm);
            chk({vecs[i].nm, "_re_pulses"}, 32'(re_cnt - re0), 32'(vecs[i].exp_re));
            chk({vecs[i].nm, "_we_pulses"}, 32'(we_cnt - we0), 32'(vecs[i].exp_we));
            if (vecs[i].exp_we != 0) chk({vecs[i].nm, "_dm_wdata"}, last_wdata, vecs[i].exp_wdata);
        end

        // Reset while a word store is in STORE: write abandoned, no response.
        v = '{"sw0_abort", 1, 2'b10, 0, 32'h0, 32'hDEADBEEF, 32'h0, 0, 2, 0, 1, 32'h0};
        @(negedge clk);
        drive(v);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("abort_dm_we_before", 32'(dm_we), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("abort_dm_we_after", 32'(dm_we), 32'd0);
        chk("abort_dm_addr", dm_addr, PARK);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        chk("abort_mem0", mem[0], 32'h01020304);
        repeat (4) @(negedge clk);

        // Two loads with req_valid held high: second accepted exactly 3 cycles later.
        @(negedge clk);
        v = '{"q1", 0, 2'b10, 0, 32'h8, 32'h0, 32'hBEEF33AB, 0, 2, 1, 0, 32'h0};
        drive(v);
        @(posedge clk);
        #1;
        acc1 = cyc;
        sb.push_back('{32'hBEEF33AB, 1'b0, cyc, 2});
        req_addr = 32'h4;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        acc2 = cyc;
        sb.push_back('{32'hCAFEF00D, 1'b0, cyc, 2});
        req_valid = 1'b0;
        chk("queued_accept_gap", 32'(acc2 - acc1), 32'd3);
        drain("queued");
        repeat (3) @(negedge clk);
        chk("queued_sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
